// File: rtl/reorder_buffer_pkg.sv
// Shared definitions for the reorder buffer slice.
// Sizes: ROB_SIZE entries addressed by ROB_POS_WID-bit positions; the occupancy
// count needs ROB_ID_WID bits so it can hold the value ROB_SIZE itself.
// Entry types: REG writes a destination register, STORE releases a store to
// the load/store buffer, BRANCH checks a predicted direction.
package reorder_buffer_pkg;

  localparam int ROB_POS_WID = 4;
  localparam int ROB_SIZE    = 2 ** ROB_POS_WID;
  localparam int ROB_ID_WID  = ROB_POS_WID + 1;
  localparam int DATA_WID    = 32;
  localparam int REG_POS_WID = 5;

  localparam logic [ROB_ID_WID-1:0] ROB_FULL_COUNT = ROB_ID_WID'(ROB_SIZE);

  typedef enum logic [1:0] {
    ROB_TYPE_REG    = 2'd0,
    ROB_TYPE_STORE  = 2'd1,
    ROB_TYPE_BRANCH = 2'd2
  } rob_type_e;

endpackage

// File: rtl/reorder_buffer_query.sv
// rob_query_port: operand tag lookup into the reorder buffer.
// Ports:
//   pos            slot being looked up (rename tag from the decoder)
//   valid, ready   per-slot occupancy and result-present bits
//   val_arr        per-slot stored result values
//   result_*       common data bus broadcast of this cycle (bypass source)
//   query_ready    slot is occupied and its value is available
//   query_val      that value; 0 for an unoccupied slot
module rob_query_port
  import reorder_buffer_pkg::*;
(
  input  logic [ROB_POS_WID-1:0] pos,
  input  logic [ROB_SIZE-1:0]    valid,
  input  logic [ROB_SIZE-1:0]    ready,
  input  logic [DATA_WID-1:0]    val_arr [ROB_SIZE],
  input  logic                   result_valid,
  input  logic [ROB_POS_WID-1:0] result_rob_pos,
  input  logic [DATA_WID-1:0]    result_val,
  output logic                   query_ready,
  output logic [DATA_WID-1:0]    query_val
);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    query_ready = 1'b0;
    query_val   = '0;
    if (valid[pos]) begin
      // The broadcast on the bus this cycle is newer than anything stored.
      if (result_valid && (result_rob_pos == pos)) begin
        query_ready = 1'b1;
        query_val   = result_val;
      end else if (ready[pos]) begin
        query_ready = 1'b1;
        query_val   = val_arr[pos];
      end
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement queue for the out-of-order RV32I core.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   rdy                        global enable; low freezes every register
//   issue, issue_type/rd/pred  allocate the tail slot
//   issue_rob_pos              tail slot = rename tag the next issue receives
//   full                       registered, all ROB_SIZE slots occupied
//   query1_*, query2_*         operand lookups with same-cycle CDB bypass
//   result_*                   common data bus write-back
//   commit, commit_rd/val/pos  register-file retire pulse and payload
//   commit_store               store retire pulse (position on commit_rob_pos)
//   rollback, rollback_pc      mispredicted branch retired; redirect target
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rdy,
  input  logic                   issue,
  input  logic [1:0]             issue_type,
  input  logic [REG_POS_WID-1:0] issue_rd,
  input  logic                   issue_pred_jump,
  output logic [ROB_POS_WID-1:0] issue_rob_pos,
  output logic                   full,
  input  logic [ROB_POS_WID-1:0] query1_pos,
  output logic                   query1_ready,
  output logic [DATA_WID-1:0]    query1_val,
  input  logic [ROB_POS_WID-1:0] query2_pos,
  output logic                   query2_ready,
  output logic [DATA_WID-1:0]    query2_val,
  input  logic                   result_valid,
  input  logic [ROB_POS_WID-1:0] result_rob_pos,
  input  logic [DATA_WID-1:0]    result_val,
  input  logic                   result_jump,
  output logic                   commit,
  output logic [REG_POS_WID-1:0] commit_rd,
  output logic [DATA_WID-1:0]    commit_val,
  output logic [ROB_POS_WID-1:0] commit_rob_pos,
  output logic                   commit_store,
  output logic                   rollback,
  output logic [DATA_WID-1:0]    rollback_pc
);

  // Queue pointers and occupancy.
  logic [ROB_POS_WID-1:0] head_q;
  logic [ROB_POS_WID-1:0] tail_q;
  logic [ROB_ID_WID-1:0]  count_q;
  logic [ROB_ID_WID-1:0]  count_next;

  // Per-slot control bits (reset) and payload (not reset).
  logic [ROB_SIZE-1:0]    valid_q;
  logic [ROB_SIZE-1:0]    ready_q;
  rob_type_e              type_q [ROB_SIZE];
  logic [REG_POS_WID-1:0] rd_q   [ROB_SIZE];
  logic [DATA_WID-1:0]    val_q  [ROB_SIZE];
  logic [ROB_SIZE-1:0]    pred_q;
  logic [ROB_SIZE-1:0]    jump_q;

  logic      retire_en;
  logic      issue_en;
  logic      result_en;
  logic      flush;
  rob_type_e head_type;

  assign head_type = type_q[head_q];

  // Retirement looks at the stored ready bit only; a result arriving this
  // cycle makes its entry retire one edge later.
  assign retire_en = rdy && !rollback && (count_q != '0) &&
                     valid_q[head_q] && ready_q[head_q];

  assign flush = retire_en && (head_type == ROB_TYPE_BRANCH) &&
                 (jump_q[head_q] != pred_q[head_q]);

  // While a rollback is being taken or is visible downstream, the front end
  // and the CDB still carry wrong-path traffic, so both are dropped.
  assign issue_en  = rdy && issue && !full && !rollback && !flush;
  assign result_en = rdy && result_valid && valid_q[result_rob_pos] &&
                     !rollback && !flush;

  always_comb begin
    count_next = count_q;
    if (flush) begin
      count_next = '0;
    end else if (issue_en && !retire_en) begin
      count_next = count_q + 1'b1;
    end else if (!issue_en && retire_en) begin
      count_next = count_q - 1'b1;
    end
  end

  // Pointers, occupancy and per-slot control bits.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      full    <= 1'b0;
      valid_q <= '0;
      ready_q <= '0;
    end else if (rdy) begin
      if (flush) begin
        head_q  <= '0;
        tail_q  <= '0;
        valid_q <= '0;
        ready_q <= '0;
      end else begin
        if (issue_en) begin
          valid_q[tail_q] <= 1'b1;
          ready_q[tail_q] <= 1'b0;
          tail_q          <= tail_q + 1'b1;
        end
        if (result_en) begin
          ready_q[result_rob_pos] <= 1'b1;
        end
        if (retire_en) begin
          valid_q[head_q] <= 1'b0;
          head_q          <= head_q + 1'b1;
        end
      end
      count_q <= count_next;
      full    <= (count_next == ROB_FULL_COUNT);
    end
  end

  // NOTE: payload arrays carry no reset; valid_q/ready_q gate every read, so their power-up contents never matter.
  always_ff @(posedge clk) begin
    if (issue_en) begin
      type_q[tail_q] <= rob_type_e'(issue_type);
      rd_q[tail_q]   <= issue_rd;
      pred_q[tail_q] <= issue_pred_jump;
    end
    if (result_en) begin
      val_q[result_rob_pos]  <= result_val;
      jump_q[result_rob_pos] <= result_jump;
    end
  end

  // Retire pulses: at most one is set per enabled edge and each clears on the
  // next enabled edge. Payload registers only move when their pulse fires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit         <= 1'b0;
      commit_store   <= 1'b0;
      rollback       <= 1'b0;
      commit_rd      <= '0;
      commit_val     <= '0;
      commit_rob_pos <= '0;
      rollback_pc    <= '0;
    end else if (rdy) begin
      commit       <= retire_en && (head_type == ROB_TYPE_REG);
      commit_store <= retire_en && (head_type == ROB_TYPE_STORE);
      rollback     <= flush;
      if (retire_en && (head_type == ROB_TYPE_REG)) begin
        commit_rd      <= rd_q[head_q];
        commit_val     <= val_q[head_q];
        commit_rob_pos <= head_q;
      end
      if (retire_en && (head_type == ROB_TYPE_STORE)) begin
        commit_rob_pos <= head_q;
      end
      if (flush) begin
        rollback_pc <= val_q[head_q];
      end
    end
  end

  assign issue_rob_pos = tail_q;

  rob_query_port u_query1 (
    .pos            (query1_pos),
    .valid          (valid_q),
    .ready          (ready_q),
    .val_arr        (val_q),
    .result_valid   (result_valid),
    .result_rob_pos (result_rob_pos),
    .result_val     (result_val),
    .query_ready    (query1_ready),
    .query_val      (query1_val)
  );

  rob_query_port u_query2 (
    .pos            (query2_pos),
    .valid          (valid_q),
    .ready          (ready_q),
    .val_arr        (val_q),
    .result_valid   (result_valid),
    .result_rob_pos (result_rob_pos),
    .result_val     (result_val),
    .query_ready    (query2_ready),
    .query_val      (query2_val)
  );

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_reorder_buffer;

  logic        clk;
  logic        rst_n;
  logic        rdy;
  logic        issue;
  logic [1:0]  issue_type;
  logic [4:0]  issue_rd;
  logic        issue_pred_jump;
  logic [3:0]  issue_rob_pos;
  logic        full;
  logic [3:0]  query1_pos;
  logic        query1_ready;
  logic [31:0] query1_val;
  logic [3:0]  query2_pos;
  logic        query2_ready;
  logic [31:0] query2_val;
  logic        result_valid;
  logic [3:0]  result_rob_pos;
  logic [31:0] result_val;
  logic        result_jump;
  logic        commit;
  logic [4:0]  commit_rd;
  logic [31:0] commit_val;
  logic [3:0]  commit_rob_pos;
  logic        commit_store;
  logic        rollback;
  logic [31:0] rollback_pc;

  reorder_buffer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rdy             (rdy),
    .issue           (issue),
    .issue_type      (issue_type),
    .issue_rd        (issue_rd),
    .issue_pred_jump (issue_pred_jump),
    .issue_rob_pos   (issue_rob_pos),
    .full            (full),
    .query1_pos      (query1_pos),
    .query1_ready    (query1_ready),
    .query1_val      (query1_val),
    .query2_pos      (query2_pos),
    .query2_ready    (query2_ready),
    .query2_val      (query2_val),
    .result_valid    (result_valid),
    .result_rob_pos  (result_rob_pos),
    .result_val      (result_val),
    .result_jump     (result_jump),
    .commit          (commit),
    .commit_rd       (commit_rd),
    .commit_val      (commit_val),
    .commit_rob_pos  (commit_rob_pos),
    .commit_store    (commit_store),
    .rollback        (rollback),
    .rollback_pc     (rollback_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [1:0] T_REG    = 2'd0;
  localparam logic [1:0] T_STORE  = 2'd1;
  localparam logic [1:0] T_BRANCH = 2'd2;

  int vectors;
  int miscompares;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: program-order list of in-flight instructions.
  typedef struct {
    logic [1:0]  typ;
    logic [4:0]  rd;
    logic        pred;
    logic        done;
    logic [31:0] val;
    logic        jump;
    logic [3:0]  pos;
  } ent_t;

  ent_t        mq[$];
  logic [3:0]  m_tail;
  logic        m_full;
  logic        m_commit;
  logic        m_store;
  logic        m_rb;
  logic [4:0]  m_rd;
  logic [31:0] m_val;
  logic [3:0]  m_pos;
  logic [31:0] m_pc;

  function automatic int find_slot(input logic [3:0] p);
    foreach (mq[i]) if (mq[i].pos == p) return i;
    return -1;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_tail = '0; m_full = 1'b0;
    m_commit = 1'b0; m_store = 1'b0; m_rb = 1'b0;
    m_rd = '0; m_val = '0; m_pos = '0; m_pc = '0;
  endtask

  // Advance the model across one clock edge using the currently driven inputs.
  task automatic model_edge();
    logic blocked, full_old, ret, flush;
    ent_t h;
    int   k;
    if (!rdy) return;
    blocked  = m_rb;
    full_old = m_full;
    ret      = (mq.size() > 0) && mq[0].done;
    flush    = 1'b0;
    m_commit = 1'b0; m_store = 1'b0; m_rb = 1'b0;
    if (ret) begin
      h = mq[0];
      if (h.typ == T_REG) begin
        m_commit = 1'b1; m_rd = h.rd; m_val = h.val; m_pos = h.pos;
      end else if (h.typ == T_STORE) begin
        m_store = 1'b1; m_pos = h.pos;
      end else if (h.typ == T_BRANCH && h.jump != h.pred) begin
        flush = 1'b1; m_rb = 1'b1; m_pc = h.val;
      end
    end
    if (flush) begin
      mq.delete();
      m_tail = '0;
    end else begin
      if (result_valid && !blocked) begin
        k = find_slot(result_rob_pos);
        if (k >= 0) begin
          mq[k].done = 1'b1; mq[k].val = result_val; mq[k].jump = result_jump;
        end
      end
      if (ret) void'(mq.pop_front());
      if (issue && !full_old && !blocked) begin
        mq.push_back('{typ: issue_type, rd: issue_rd, pred: issue_pred_jump,
                       done: 1'b0, val: '0, jump: 1'b0, pos: m_tail});
        m_tail = m_tail + 1'b1;
      end
    end
    m_full = (mq.size() == 16);
  endtask

  task automatic check_query(input string tag, input logic [3:0] p,
                             input logic got_r, input logic [31:0] got_v);
    int          k;
    logic        exp_r;
    logic [31:0] exp_v;
    k = find_slot(p);
    exp_r = 1'b0; exp_v = '0;
    if (k >= 0) begin
      if (result_valid && result_rob_pos == p) begin
        exp_r = 1'b1; exp_v = result_val;
      end else if (mq[k].done) begin
        exp_r = 1'b1; exp_v = mq[k].val;
      end
    end
    check({tag, "_ready"}, 32'(got_r), 32'(exp_r));
    if (exp_r || k < 0) check({tag, "_val"}, got_v, exp_v);
  endtask

  task automatic check_regs();
    check("full", 32'(full), 32'(m_full));
    check("commit", 32'(commit), 32'(m_commit));
    check("commit_store", 32'(commit_store), 32'(m_store));
    check("rollback", 32'(rollback), 32'(m_rb));
    if (m_commit) begin
      check("commit_rd", 32'(commit_rd), 32'(m_rd));
      check("commit_val", commit_val, m_val);
    end
    if (m_commit || m_store) check("commit_rob_pos", 32'(commit_rob_pos), 32'(m_pos));
    if (m_rb) check("rollback_pc", rollback_pc, m_pc);
  endtask

  // One clock cycle; called and returns at a falling edge.
  task automatic step(input logic i_rdy, input logic i_issue, input logic [1:0] i_type,
                      input logic [4:0] i_rd, input logic i_pred, input logic i_rv,
                      input logic [3:0] i_rpos, input logic [31:0] i_rval,
                      input logic i_rjump, input logic [3:0] q1, input logic [3:0] q2);
    rdy = i_rdy; issue = i_issue; issue_type = i_type; issue_rd = i_rd;
    issue_pred_jump = i_pred; result_valid = i_rv; result_rob_pos = i_rpos;
    result_val = i_rval; result_jump = i_rjump; query1_pos = q1; query2_pos = q2;
    #1;
    check("issue_rob_pos", 32'(issue_rob_pos), 32'(m_tail));
    check_query("query1", q1, query1_ready, query1_val);
    check_query("query2", q2, query2_ready, query2_val);
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_regs();
  endtask

  task automatic do_issue(input logic [1:0] t, input logic [4:0] rd, input logic pred);
    step(1'b1, 1'b1, t, rd, pred, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd1);
  endtask

  task automatic do_result(input logic [3:0] p, input logic [31:0] v, input logic j);
    step(1'b1, 1'b0, T_REG, 5'd0, 1'b0, 1'b1, p, v, j, p, 4'd15);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b1, 1'b0, T_REG, 5'd0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0,
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
  endtask

  // Asynchronous reset between edges; outputs must clear without a clock.
  task automatic do_reset();
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_commit", 32'(commit), 32'd0);
    check("rst_commit_store", 32'(commit_store), 32'd0);
    check("rst_rollback", 32'(rollback), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_commit_rd", 32'(commit_rd), 32'd0);
    check("rst_commit_val", commit_val, 32'd0);
    check("rst_commit_rob_pos", 32'(commit_rob_pos), 32'd0);
    check("rst_rollback_pc", rollback_pc, 32'd0);
    check("rst_issue_rob_pos", 32'(issue_rob_pos), 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic rand_step();
    logic        i_rdy, i_issue, i_pred, i_rv, i_rjump;
    logic [1:0]  i_type;
    logic [3:0]  i_rpos, q2;
    int          k;
    i_rdy   = ($urandom_range(0, 9) != 0);
    i_issue = ($urandom_range(0, 9) < 6);
    i_type  = 2'($urandom_range(0, 2));
    i_pred  = 1'($urandom_range(0, 1));
    i_rv    = ($urandom_range(0, 3) != 0);
    i_rjump = 1'($urandom_range(0, 1));
    i_rpos  = 4'($urandom_range(0, 15));
    q2      = 4'($urandom_range(0, 15));
    if (mq.size() > 0) begin
      k = $urandom_range(0, mq.size() - 1);
      q2 = mq[k].pos;
      if ($urandom_range(0, 3) != 0) begin
        k = $urandom_range(0, mq.size() - 1);
        i_rpos = mq[k].pos;
        if (mq[k].typ == T_BRANCH)
          i_rjump = ($urandom_range(0, 5) == 0) ? !mq[k].pred : mq[k].pred;
      end
    end
    step(i_rdy, i_issue, i_type, 5'($urandom_range(0, 31)), i_pred, i_rv, i_rpos,
         $urandom, i_rjump, 4'($urandom_range(0, 15)), q2);
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst_n = 1'b0; rdy = 1'b1; issue = 1'b0; issue_type = T_REG; issue_rd = '0;
    issue_pred_jump = 1'b0; result_valid = 1'b0; result_rob_pos = '0;
    result_val = '0; result_jump = 1'b0; query1_pos = '0; query2_pos = '0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Single REG entry through to commit.
    do_issue(T_REG, 5'd5, 1'b0);
    do_result(4'd0, 32'h1234, 1'b0);
    idle(3);

    // Out-of-order results, in-order commits.
    do_issue(T_REG, 5'd1, 1'b0);
    do_issue(T_REG, 5'd2, 1'b0);
    do_result(4'd2, 32'hAAAA_0002, 1'b0);
    idle(1);
    do_result(4'd1, 32'hAAAA_0001, 1'b0);
    idle(3);

    // Fill, refused 17th issue, free one slot, tail wrap.
    do_reset();
    for (int i = 0; i < 16; i++) do_issue(T_STORE, 5'(i), 1'b0);
    do_issue(T_REG, 5'd31, 1'b0);
    do_result(4'd0, 32'h5555, 1'b0);
    do_issue(T_REG, 5'd30, 1'b0);
    do_issue(T_REG, 5'd29, 1'b0);
    idle(2);

    // Same-cycle bypass query and invalid-slot query.
    do_reset();
    for (int i = 0; i < 4; i++) do_issue(T_REG, 5'(i + 8), 1'b0);
    step(1'b1, 1'b0, T_REG, 5'd0, 1'b0, 1'b1, 4'd3, 32'hBEEF, 1'b0, 4'd3, 4'd10);
    idle(2);

    // Mispredicted branch with younger entries; wrong-path traffic is dropped.
    do_reset();
    do_issue(T_BRANCH, 5'd0, 1'b0);
    do_issue(T_REG, 5'd3, 1'b0);
    do_issue(T_REG, 5'd4, 1'b0);
    do_result(4'd1, 32'h11, 1'b0);
    do_result(4'd2, 32'h22, 1'b0);
    do_result(4'd0, 32'h100, 1'b1);
    step(1'b1, 1'b1, T_REG, 5'd7, 1'b0, 1'b1, 4'd2, 32'h33, 1'b0, 4'd1, 4'd2);
    step(1'b1, 1'b1, T_REG, 5'd8, 1'b0, 1'b1, 4'd0, 32'h44, 1'b0, 4'd0, 4'd1);
    idle(3);

    // rdy low with a ready head, then a pending pulse held across rdy low.
    do_reset();
    do_issue(T_REG, 5'd9, 1'b0);
    do_result(4'd0, 32'h9999, 1'b0);
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, T_REG, 5'd1, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd1);
    idle(1);
    step(1'b0, 1'b0, T_REG, 5'd0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd0);
    idle(2);

    // Randomized traffic with a reset in the middle.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      rand_step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
